load_store_unit: RTL and testbench

- Memory-access stage directly downstream of the register/ALU datapath.
- Takes the ALU result as the effective address and rs2 as store data, then performs one RV32I load or store over a simple req/ack memory bus.
- Returns aligned, sign- or zero-extended load data for register writeback.
- The multi-cycle controller holds `start` operands stable and waits for `done`.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/load_align.sv | 28 ++
 rtl/load_store_unit.sv | 191 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// error codes and the byte-enable helper used for both loads and stores.
package lsu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned BE_W  = 4;
  localparam int unsigned CNT_W = 10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_e;

  // Byte enables from access size (funct3[1:0]) and the low address bits.
  function automatic logic [BE_W-1:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
    logic [BE_W-1:0] be;
    case (f3[1:0])
      2'b00:   be = BE_W'(4'b0001 << a);
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: selects the byte/halfword lane addressed by
// a[1:0] from the bus word and sign- or zero-extends it per funct3.
// Ports: rdata (bus word), funct3, a (addr[1:0]) -> data (32-bit result).
module load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      a,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{a, 3'b000} +: 8];
    half_sel = a[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one load or store per start over a req/ack bus,
// with illegal-funct3, misalignment and bus-timeout faults.
// Ports: clk, rst (async active-high); start/is_store/funct3/addr/store_data
// from the controller; busy/done/load_data/err_code back to it; mem_* bus.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] load_data,
  output logic [1:0]      err_code,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e      state_q, state_d;
  logic            is_store_q, is_store_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      a_lo_q, a_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] load_data_q, load_data_d;
  logic [1:0]      err_q, err_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0] mem_be_q, mem_be_d;

  logic            legal_c;
  logic            misalign_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] fmt_c;

  load_align u_load_align (
    .rdata  (mem_rdata),
    .funct3 (funct3_q),
    .a      (a_lo_q),
    .data   (fmt_c)
  );

  // Legality, alignment and store-lane replication for the incoming request.
  always_comb begin
    if (is_store) legal_c = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else          legal_c = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                            (funct3 == F3_BU) || (funct3 == F3_HU);
    case (funct3[1:0])
      2'b01:   misalign_c = addr[0];
      2'b10:   misalign_c = (addr[1:0] != 2'b00);
      default: misalign_c = 1'b0;
    endcase
    case (funct3[1:0])
      2'b00:   wdata_c = {4{store_data[7:0]}};
      2'b01:   wdata_c = {2{store_data[15:0]}};
      default: wdata_c = store_data;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    a_lo_d      = a_lo_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    load_data_d = load_data_q;
    err_d       = err_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          a_lo_d     = addr[1:0];
          if (!legal_c) begin
            err_d   = ERR_ILLEGAL;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (misalign_c) begin
            err_d   = ERR_MISALIGN;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d     = ACCESS;
            busy_d      = 1'b1;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_be_d    = lane_be(funct3, addr[1:0]);
            mem_wdata_d = wdata_c;
          end
        end
      end
      ACCESS: begin
        // Ack takes precedence over a timeout expiring in the same cycle.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          err_d     = ERR_NONE;
          if (!is_store_q) load_data_d = fmt_c;
          state_d   = DONE;
        end else if (cnt_q == CNT_LAST) begin
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          err_d     = ERR_TIMEOUT;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      a_lo_q      <= 2'b00;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_data_q <= '0;
      err_q       <= ERR_NONE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      a_lo_q      <= a_lo_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      load_data_q <= load_data_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign load_data = load_data_q;
  assign err_code  = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT_CYCLES = 4).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        busy, done;
  logic [31:0] load_data;
  logic [1:0]  err_code;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;

  // Results of the last op() call.
  int          lat;
  int          req_cycles;
  logic        saw_req;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .err_code   (err_code),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one access; ack is presented in the ack_at-th cycle after the
  // start edge (if mem_req is high). Returns with done visible.
  task automatic op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] sd, input logic [31:0] rd, input int ack_at);
    logic got_done;
    got_done   = 1'b0;
    lat        = 0;
    req_cycles = 0;
    saw_req    = 1'b0;
    is_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    mem_rdata  = rd;
    start      = 1'b1;
    while (!got_done && lat < 40) begin
      tick();
      lat++;
      start   = 1'b0;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (!saw_req) begin
          cap_addr  = mem_addr;
          cap_wdata = mem_wdata;
          cap_be    = mem_be;
          cap_we    = mem_we;
        end
        saw_req = 1'b1;
        req_cycles++;
      end
      if (done) got_done = 1'b1;
      else if (mem_req && lat == ack_at) mem_ack = 1'b1;
    end
    if (!got_done) check("done_wait", 32'd0, 32'd1);
  endtask

  initial begin
    #3;
    check("rst_req",   32'(mem_req), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_ldata", load_data, 32'd0);
    check("rst_err",   32'(err_code), 32'd0);
    #9 rst = 1'b0;

    // LW, ack one cycle after req
    op(1'b0, 3'b010, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 2);
    check("lw_addr",  cap_addr, 32'h0000_1004);
    check("lw_be",    32'(cap_be), 32'hF);
    check("lw_we",    32'(cap_we), 32'd0);
    check("lw_lat",   32'(lat), 32'd3);
    check("lw_data",  load_data, 32'hDEAD_BEEF);
    check("lw_err",   32'(err_code), 32'd0);
    check("lw_req_off", 32'(mem_req), 32'd0);
    check("lw_busy_off", 32'(busy), 32'd0);
    tick();
    check("lw_done_pulse", 32'(done), 32'd0);

    // LB / LBU / LH lane selection
    op(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_0000, 1);
    check("lb_be",   32'(cap_be), 32'h8);
    check("lb_data", load_data, 32'hFFFF_FF80);
    tick();
    op(1'b0, 3'b100, 32'h0000_1003, 32'd0, 32'h80FF_0000, 1);
    check("lbu_data", load_data, 32'h0000_0080);
    tick();
    op(1'b0, 3'b001, 32'h0000_1002, 32'd0, 32'h80FF_0000, 1);
    check("lh_be",   32'(cap_be), 32'hC);
    check("lh_data", load_data, 32'hFFFF_80FF);
    tick();

    // SB zero-wait
    op(1'b1, 3'b000, 32'h0000_2001, 32'h1234_56AB, 32'h0BAD_0BAD, 1);
    check("sb_be",    32'(cap_be), 32'h2);
    check("sb_wdata", cap_wdata, 32'hABAB_ABAB);
    check("sb_we",    32'(cap_we), 32'd1);
    check("sb_addr",  cap_addr, 32'h0000_2000);
    check("sb_lat",   32'(lat), 32'd2);
    check("sb_ldata", load_data, 32'hFFFF_80FF);
    tick();

    // SH misaligned
    op(1'b1, 3'b001, 32'h0000_2003, 32'h0000_5555, 32'd0, 1);
    check("sh_mis_lat", 32'(lat), 32'd1);
    check("sh_mis_err", 32'(err_code), 32'd1);
    check("sh_mis_req", 32'(saw_req), 32'd0);
    check("sh_mis_busy", 32'(busy), 32'd0);
    tick();
    check("err_hold", 32'(err_code), 32'd1);

    // Illegal funct3 outranks misalignment
    op(1'b0, 3'b011, 32'h0000_1001, 32'd0, 32'd0, 1);
    check("ill_err",   32'(err_code), 32'd2);
    check("ill_lat",   32'(lat), 32'd1);
    check("ill_req",   32'(saw_req), 32'd0);
    check("ill_ldata", load_data, 32'hFFFF_80FF);
    tick();
    op(1'b1, 3'b100, 32'h0000_1000, 32'd0, 32'd0, 1);
    check("ill_st_err", 32'(err_code), 32'd2);
    tick();

    // Timeout with no ack
    op(1'b0, 3'b010, 32'h0000_1008, 32'd0, 32'h1111_1111, 99);
    check("to_req_cycles", 32'(req_cycles), 32'd4);
    check("to_err",   32'(err_code), 32'd3);
    check("to_req",   32'(mem_req), 32'd0);
    check("to_ldata", load_data, 32'hFFFF_80FF);
    tick();

    // Ack in the final allowed cycle wins over timeout
    op(1'b0, 3'b101, 32'h0000_1002, 32'd0, 32'hABCD_0000, 4);
    check("late_ack_err",  32'(err_code), 32'd0);
    check("late_ack_lat",  32'(lat), 32'd5);
    check("late_ack_data", load_data, 32'h0000_ABCD);
    tick();

    // SW
    op(1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 32'd0, 1);
    check("sw_be",    32'(cap_be), 32'hF);
    check("sw_wdata", cap_wdata, 32'hCAFE_F00D);
    check("sw_ldata", load_data, 32'h0000_ABCD);
    tick();

    // Asynchronous reset mid-access
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_1010; start = 1'b1;
    tick();
    start = 1'b0;
    check("pre_rst_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_req",  32'(mem_req), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_ldata", load_data, 32'd0);
    #3 rst = 1'b0;
    op(1'b0, 3'b010, 32'h0000_1004, 32'd0, 32'h1122_3344, 1);
    check("post_rst_lat",  32'(lat), 32'd2);
    check("post_rst_data", load_data, 32'h1122_3344);
    tick();

    // start while busy is ignored
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_1020;
    mem_rdata = 32'h55AA_55AA; start = 1'b1;
    tick();
    start = 1'b0;
    check("bsy_busy", 32'(busy), 32'd1);
    tick();
    is_store = 1'b1; addr = 32'h0000_2000; start = 1'b1;
    tick();
    start = 1'b0;
    check("bsy_addr", mem_addr, 32'h0000_1020);
    check("bsy_we",   32'(mem_we), 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("bsy_done", 32'(done), 32'd1);
    check("bsy_data", load_data, 32'h55AA_55AA);
    tick();
    check("bsy_done_off", 32'(done), 32'd0);
    check("bsy_req_off",  32'(mem_req), 32'd0);
    tick();
    check("bsy_no_second", 32'(mem_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
